// File: rtl/and3_rr_scheduler_if.sv
// Handshake bundle for and3_rr_scheduler.
// master: requesters plus result consumer (drives requests, resp_ready).
// slave : the scheduler (drives req_ready and the registered response).
//   req_valid/req_ready  per-requester handshake, bit i = requester i
//   req_a/req_b/req_c    packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/ready     response handshake
//   resp_data/resp_id    registered result and the requester index that produced it
//   op_count             completed response handshakes, wraps at 16 bits
interface and3_rr_scheduler_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 3
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*WIDTH-1:0] req_c;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH-1:0]         resp_data;
  logic [IDW-1:0]           resp_id;
  logic [15:0]              op_count;

  modport master (
    output req_valid, req_a, req_b, req_c, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, op_count
  );
endinterface

// File: rtl/and3_rr_scheduler.sv
// Round-robin scheduler sharing one a & b & c datapath among NUM_REQ requesters.
// A single result register holds the output until the consumer accepts it; a new
// request may be accepted in the same cycle the held result drains, so a result
// can be produced every cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    and3_rr_scheduler_if slave modport (request and response handshakes)
module and3_rr_scheduler #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  and3_rr_scheduler_if.slave    bus
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [15:0]        count_q, count_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [WIDTH-1:0]   grant_result;
  logic               slot_free;
  logic               req_xfer;
  logic               resp_hs;

  // Cyclic priority search starting at ptr_q.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && bus.req_valid[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  // Shared datapath: mux the granted operands, then one AND3.
  always_comb begin
    grant_result = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        grant_result = bus.req_a[k*WIDTH +: WIDTH] & bus.req_b[k*WIDTH +: WIDTH]
                     & bus.req_c[k*WIDTH +: WIDTH];
      end
    end
  end

  // The slot also counts as free when the held result drains this cycle.
  assign slot_free = (state_q == StEmpty) || bus.resp_ready;
  assign req_xfer  = slot_free && grant_found;
  assign resp_hs   = (state_q == StFull) && bus.resp_ready;

  // req_ready is gated by rst_n so it drops immediately on asynchronous reset.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && req_xfer) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    count_d = count_q;

    if (resp_hs) begin
      count_d = count_q + 16'd1;
    end

    if (req_xfer) begin
      data_d = grant_result;
      id_d   = grant_idx;
      ptr_d  = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    unique case (state_q)
      StEmpty: if (req_xfer) state_d = StFull;
      StFull:  if (bus.resp_ready && !req_xfer) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      count_q <= count_d;
    end
  end

  assign bus.resp_valid = (state_q == StFull);
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = id_q;
  assign bus.op_count   = count_q;
endmodule

// File: tb/tb_and3_rr_scheduler.sv
module tb_and3_rr_scheduler;
  localparam int N = 3;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  and3_rr_scheduler_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  and3_rr_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus state
  logic [N-1:0] vld;
  logic         rr;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic [W-1:0] op_c [N];

  // Reference model: held result and rotating priority start
  int           m_ptr;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  int           m_count;

  typedef struct {
    logic [N-1:0] vld;
    logic         rr;
    logic [N-1:0] ready;
    logic         rvalid;
    logic [W-1:0] data;
    logic [1:0]   id;
    logic [15:0]  cnt;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req_valid  = vld;
    bus.resp_ready = rr;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = op_a[i];
      bus.req_b[i*W +: W] = op_b[i];
      bus.req_c[i*W +: W] = op_c[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; m_count = 0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Apply current inputs for one clock, checking req_ready before the edge and
  // the registered response after it.
  task automatic tick();
    int g;
    logic free;
    logic [N-1:0] er;
    drive();
    #1;
    free = !m_valid || rr;
    g = model_grant();
    er = (free && g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 32'(bus.req_ready), 32'(er));
    if (m_valid && rr) m_count = (m_count + 1) % 65536;
    if (free && g >= 0) begin
      m_data  = op_a[g] & op_b[g] & op_c[g];
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
    check("resp_data", 32'(bus.resp_data), 32'(m_data));
    check("resp_id", 32'(bus.resp_id), 32'(m_id));
    check("op_count", 32'(bus.op_count), 32'(m_count));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld = '0; rr = 1'b0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_fixed_ops();
    op_a[0] = 8'hFF; op_b[0] = 8'h0F; op_c[0] = 8'h3C;  // -> 0x0C
    op_a[1] = 8'hF0; op_b[1] = 8'hCC; op_c[1] = 8'hAA;  // -> 0x80
    op_a[2] = 8'h3C; op_b[2] = 8'hFF; op_c[2] = 8'hFF;  // -> 0x3C
  endtask

  initial begin
    vld = '0; rr = 1'b0;
    set_fixed_ops();
    drive();
    model_reset();

    tbl[0] = '{3'b010, 1'b1, 3'b010, 1'b1, 8'h80, 2'd1, 16'd0};
    tbl[1] = '{3'b000, 1'b1, 3'b000, 1'b0, 8'h80, 2'd1, 16'd1};
    tbl[2] = '{3'b111, 1'b1, 3'b100, 1'b1, 8'h3C, 2'd2, 16'd1};
    tbl[3] = '{3'b111, 1'b0, 3'b000, 1'b1, 8'h3C, 2'd2, 16'd1};
    tbl[4] = '{3'b011, 1'b1, 3'b001, 1'b1, 8'h0C, 2'd0, 16'd2};
    tbl[5] = '{3'b101, 1'b1, 3'b100, 1'b1, 8'h3C, 2'd2, 16'd3};
    tbl[6] = '{3'b000, 1'b1, 3'b000, 1'b0, 8'h3C, 2'd2, 16'd4};

    // Reset state
    do_reset();
    #1;
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_data", 32'(bus.resp_data), 32'd0);
    check("rst op_count", 32'(bus.op_count), 32'd0);

    // Table-driven vectors
    for (int t = 0; t < 7; t++) begin
      vld = tbl[t].vld; rr = tbl[t].rr;
      drive();
      #1;
      check($sformatf("tbl%0d ready", t), 32'(bus.req_ready), 32'(tbl[t].ready));
      tick();
      check($sformatf("tbl%0d rvalid", t), 32'(bus.resp_valid), 32'(tbl[t].rvalid));
      check($sformatf("tbl%0d data", t), 32'(bus.resp_data), 32'(tbl[t].data));
      check($sformatf("tbl%0d id", t), 32'(bus.resp_id), 32'(tbl[t].id));
      check($sformatf("tbl%0d cnt", t), 32'(bus.op_count), 32'(tbl[t].cnt));
    end

    // Round robin with everyone requesting
    do_reset();
    vld = 3'b111; rr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr id seq", 32'(bus.resp_id), 32'(k % 3));
      check("rr valid", 32'(bus.resp_valid), 32'd1);
    end
    vld = '0;
    tick();
    check("rr count6", 32'(bus.op_count), 32'd6);

    // Backpressure on requester 2, with requester 0 requesting then withdrawing
    do_reset();
    vld = 3'b100; rr = 1'b0;
    tick();
    vld = 3'b101;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp data", 32'(bus.resp_data), 32'h3C);
      check("bp id", 32'(bus.resp_id), 32'd2);
      check("bp ready", 32'(bus.req_ready), 32'd0);
      check("bp cnt", 32'(bus.op_count), 32'd0);
    end
    vld = 3'b100;
    tick();
    rr = 1'b1;
    drive();
    #1;
    check("bp release ready", 32'(bus.req_ready), 32'b100);
    tick();
    check("bp regrant id", 32'(bus.resp_id), 32'd2);
    check("bp regrant valid", 32'(bus.resp_valid), 32'd1);
    check("bp cnt1", 32'(bus.op_count), 32'd1);
    vld = '0;
    tick();
    check("withdrawn no id0", 32'(bus.resp_id), 32'd2);
    check("drain cnt", 32'(bus.op_count), 32'd2);

    // Asynchronous reset while a result is held
    do_reset();
    vld = 3'b111; rr = 1'b1;
    repeat (3) tick();
    rr = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("arst resp_data", 32'(bus.resp_data), 32'd0);
    check("arst resp_id", 32'(bus.resp_id), 32'd0);
    check("arst op_count", 32'(bus.op_count), 32'd0);
    check("arst req_ready", 32'(bus.req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rr = 1'b1;
    tick();
    check("arst first grant", 32'(bus.resp_id), 32'd0);

    // Counter wrap
    do_reset();
    vld = 3'b111; rr = 1'b1;
    for (int k = 0; k < 65536; k++) tick();
    check("cnt ffff", 32'(bus.op_count), 32'hFFFF);
    tick();
    check("cnt wrap", 32'(bus.op_count), 32'h0000);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      vld = N'($urandom_range(0, (1 << N) - 1));
      rr  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        op_a[i] = W'($urandom); op_b[i] = W'($urandom); op_c[i] = W'($urandom);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
